join_digits: RTL
================

JOIN_DIGITS -- requirements
Module: JOIN_DIGITS

Interface
REQ-001 SHALL provide parameter: MAX_VAL, default 59, largest accepted binary result (legal 0..63).
REQ-002 SHALL provide port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: DIGIT_IN  input  4  BCD digit from keypad/entry logic.
REQ-005 SHALL provide port: DIGIT_VALID  input  1  DIGIT_IN valid this cycle.
REQ-006 SHALL provide port: DIGIT_READY  output  1  block can accept a digit this cycle.
REQ-007 SHALL provide port: CLEAR  input  1  synchronous abort of entry in progress.
REQ-008 SHALL provide port: DATA  output  6  last successfully joined binary value.
REQ-009 SHALL provide port: DONE  output  1  one-cycle pulse: DATA updated.
REQ-010 SHALL provide port: ERR  output  1  one-cycle pulse: digit or range error.
REQ-011 SHALL provide port: BUSY  output  1  high in every state except IDLE.
REQ-012 SHALL provide port: TENS_SHOWN  output  4  registered echo of accepted tens digit for display.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_ONES, ACCUM, CHECK.
REQ-014 SHALL accept a digit only on an edge where DIGIT_VALID and DIGIT_READY are both high.
REQ-015 SHALL drive DIGIT_READY high exactly in IDLE and WAIT_ONES.
REQ-016 IDLE: accepted digit <=9 -> store as tens count, TENS_SHOWN <= digit, go WAIT_ONES.
REQ-017 WAIT_ONES: accepted digit <=9 -> accumulator (7 bit) <= digit, go ACCUM.
REQ-018 Accepted digit >9 in IDLE or WAIT_ONES -> discarded, ERR pulses for one cycle after that edge, state unchanged.
REQ-019 ACCUM: each edge with tens count nonzero -> accumulator += 10, tens count -= 1; edge with count zero -> go CHECK.
REQ-020 CHECK: accumulator <= MAX_VAL -> DATA <= accumulator[5:0], DONE pulse; else ERR pulse, DATA unchanged; always go IDLE.
REQ-021 Latency: DONE/ERR from CHECK high for exactly one cycle, starting (tens+2) rising edges after the edge accepting the ones digit.
REQ-022 DONE and ERR SHALL never be high in the same cycle; each is low in all other cycles.
REQ-023 CLEAR high at an edge -> state IDLE, tens count and TENS_SHOWN cleared, no DONE/ERR, DATA unchanged; CLEAR wins over a simultaneous digit handshake (digit discarded).
REQ-024 Accumulator SHALL be wide enough for 99 without wrap; comparison against MAX_VAL uses full width.
REQ-025 DATA SHALL hold its value between DONE pulses, including across CLEAR and ERR.

Reset
REQ-026 RST high SHALL immediately force state IDLE, DATA=0, DONE=0, ERR=0, BUSY=0, TENS_SHOWN=0, accumulator and tens count 0; DIGIT_READY=1.
REQ-027 RST asserted mid-entry (any state) SHALL abandon the entry with no DONE/ERR pulse.
REQ-028 After RST deasserts, first accepted digit SHALL be treated as a tens digit.

Verification
REQ-029 Digits 4 then 2 -> DONE one cycle, 6 edges after ones accept; DATA=42; ERR=0 throughout.
REQ-030 Digits 0 then 7 -> DONE 2 edges after ones accept; DATA=7.
REQ-031 MAX_VAL=59, DATA=42, digits 6 then 3 -> ERR pulse 8 edges after ones accept; DATA stays 42; no DONE.
REQ-032 Tens digit 0xB -> ERR pulse next cycle, state IDLE, DIGIT_READY=1; then 1, 5 -> DATA=15, DONE.
REQ-033 Digit 3 accepted, then CLEAR with DIGIT_VALID=1 and DIGIT_IN=5 same edge -> IDLE, TENS_SHOWN=0, no pulse; then 2, 0 -> DATA=20.
REQ-034 Digits 9, 9 with MAX_VAL=63, RST during ACCUM -> all outputs reset values immediately, no DONE/ERR; then 1, 1 -> DATA=11.

Source files
------------

// File: rtl/join_digits.sv
// ============================================================================
// Module   : join_digits
// Purpose  : Joins a BCD tens digit and ones digit into a range-checked value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module join_digits #(
  parameter int MAX_VAL = 59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIGIT_IN,
  input  logic       DIGIT_VALID,
  output logic       DIGIT_READY,
  input  logic       CLEAR,
  output logic [5:0] DATA,
  output logic       DONE,
  output logic       ERR,
  output logic       BUSY,
  output logic [3:0] TENS_SHOWN
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ONES = 2'd1,
    S_ACCUM     = 2'd2,
    S_CHECK     = 2'd3
  } state_t;

  localparam logic [6:0] MAX_VAL_C = 7'(MAX_VAL);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] acc_q, acc_d;
  logic [5:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] shown_q, shown_d;

  logic accept;
  logic digit_ok;

  assign DIGIT_READY = (state_q == S_IDLE) || (state_q == S_WAIT_ONES);
  assign BUSY        = (state_q != S_IDLE);
  assign accept      = DIGIT_VALID && DIGIT_READY;
  assign digit_ok    = (DIGIT_IN <= 4'd9);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    acc_d   = acc_q;
    data_d  = data_q;
    shown_d = shown_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Abort takes priority over any handshake or pending check.
    if (CLEAR) begin
      state_d = S_IDLE;
      tens_d  = 4'd0;
      shown_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (digit_ok) begin
              tens_d  = DIGIT_IN;
              shown_d = DIGIT_IN;
              state_d = S_WAIT_ONES;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WAIT_ONES: begin
          if (accept) begin
            if (digit_ok) begin
              acc_d   = {3'b000, DIGIT_IN};
              state_d = S_ACCUM;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ACCUM: begin
          // Multiply-free join: add ten once per remaining tens count.
          if (tens_q != 4'd0) begin
            acc_d  = acc_q + 7'd10;
            tens_d = tens_q - 4'd1;
          end else begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (acc_q <= MAX_VAL_C) begin
            data_d = acc_q[5:0];
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      acc_q   <= 7'd0;
      data_q  <= 6'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      shown_q <= 4'd0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      shown_q <= shown_d;
    end
  end

  assign DATA       = data_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign TENS_SHOWN = shown_q;

endmodule

`default_nettype wire
